// File: rtl/rbuf_pkg.sv
// Shared types and defaults for the ring-buffer write controller.
// FSM encodings match the BRAM-side bring-up documentation.
package rbuf_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int M_DEF    = 4;
  localparam int ADDR_DEF = 5;
  localparam int DATA_DEF = 12;

endpackage

// File: rtl/rbuf_ring_rise_det.sv
// Rising-edge detector with a registered history bit.
// A level held high yields a single-cycle pulse.
module rise_det (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic pulse
);

  logic d_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) d_q <= 1'b0;
    else      d_q <= d;
  end

  assign pulse = d & ~d_q;

endmodule

// File: rtl/rbuf_ring.sv
// Ring-buffer write controller: one BRAM write per en rise,
// head wraps over M slots, done pulses after each commit.
module rbuf_ring
  import rbuf_pkg::*;
#(
  parameter int M         = M_DEF,
  parameter int ADDR_SIZE = ADDR_DEF,
  parameter int DATA_SIZE = DATA_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic [DATA_SIZE-1:0] di,
  output logic [ADDR_SIZE-1:0] addr,
  output logic [DATA_SIZE-1:0] dout,
  output logic                 owe,
  output logic                 done
);

  localparam logic [ADDR_SIZE-1:0] LAST =
    ADDR_SIZE'(M - 1);

  state_t               state, state_n;
  logic [ADDR_SIZE-1:0] head, head_n;
  logic [ADDR_SIZE-1:0] addr_n;
  logic [DATA_SIZE-1:0] dout_n;
  logic                 owe_n, done_n;
  logic                 rise;

  rise_det u_rise (
    .clk   (clk),
    .rst   (rst),
    .d     (en),
    .pulse (rise)
  );

  // Outputs are computed for the next state so they register cleanly.
  always_comb begin
    state_n = state;
    head_n  = head;
    addr_n  = addr;
    dout_n  = dout;
    owe_n   = 1'b0;
    done_n  = 1'b0;
    unique case (1'b1)
      (state == IDLE): begin
        if (rise) begin
          addr_n  = head;
          dout_n  = di;
          owe_n   = 1'b1;
          state_n = WRITE;
        end
      end
      (state == WRITE): begin
        head_n  = (head == LAST) ? '0
                                 : head + 1'b1;
        done_n  = 1'b1;
        state_n = DONE;
      end
      (state == DONE): begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      head  <= '0;
      addr  <= '0;
      dout  <= '0;
      owe   <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_n;
      head  <= head_n;
      addr  <= addr_n;
      dout  <= dout_n;
      owe   <= owe_n;
      done  <= done_n;
    end
  end

endmodule

// File: tb/tb_rbuf_ring.sv
// Scoreboard bench for rbuf_ring with an external BRAM model
// and a slot-count reference model.
module tb_rbuf_ring;

  localparam int M  = 4;
  localparam int AW = 5;
  localparam int DW = 12;

  logic          clk;
  logic          rst;
  logic          en;
  logic [DW-1:0] di;
  logic [AW-1:0] addr;
  logic [DW-1:0] dout;
  logic          owe;
  logic          done;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } wr_t;

  wr_t           sb[$];
  int            wr_count;
  logic [DW-1:0] ref_mem [M];
  logic [DW-1:0] bram    [32];
  logic          bram_wr [32];

  logic          prev_owe;
  logic [AW-1:0] last_addr;
  logic [DW-1:0] last_dout;

  rbuf_ring #(
    .M(M), .ADDR_SIZE(AW), .DATA_SIZE(DW)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .di(di),
    .addr(addr), .dout(dout),
    .owe(owe), .done(done)
  );

  initial clk = 1'b0;
  always #4 clk = ~clk;

  task automatic check(input bit ok, input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h",
               name, act, exp);
    end
  endtask

  // Monitor: samples on the falling edge, mid-cycle.
  always @(negedge clk) begin
    if (!rst) begin
      check({addr, dout, owe, done} == '0,
            "reset_outs", {addr, dout, owe, done}, 0);
      prev_owe = 1'b0;
    end else begin
      if (owe) begin
        if (sb.size() == 0) begin
          check(0, "spurious_owe", addr, 0);
        end else begin
          wr_t e;
          e = sb.pop_front();
          check(addr == e.a, "wr_addr", addr, e.a);
          check(dout == e.d, "wr_data", dout, e.d);
        end
        bram[addr]    = dout;
        bram_wr[addr] = 1'b1;
        last_addr     = addr;
        last_dout     = dout;
      end
      check(done == prev_owe, "done_follows",
            done, prev_owe);
      if (prev_owe)
        check(owe == 1'b0, "owe_width", owe, 0);
      if (done)
        check(addr == last_addr && dout == last_dout,
              "hold_in_done", {addr, dout},
              {last_addr, last_dout});
      prev_owe = owe;
    end
  end

  function automatic void push(input logic [DW-1:0] d);
    wr_t e;
    e.a = AW'(wr_count % M);
    e.d = d;
    sb.push_back(e);
    ref_mem[wr_count % M] = d;
    wr_count++;
  endfunction

  task automatic do_reset(input int cyc);
    @(posedge clk); #1;
    rst = 1'b0;
    en  = 1'b0;
    sb.delete();
    wr_count = 0;
    repeat (cyc) @(posedge clk);
    #1 rst = 1'b1;
  endtask

  // en held for 'hold' cycles; returns after done falls.
  task automatic sample(input logic [DW-1:0] d,
                        input int hold);
    bit seen = 0;
    bit ok   = 0;
    @(posedge clk); #1;
    en = 1'b1;
    di = d;
    push(d);
    for (int c = 0; c < 60; c++) begin
      @(posedge clk); #1;
      if (c + 1 >= hold) en = 1'b0;
      if (done) seen = 1;
      if (seen && !done && c + 1 >= hold) begin
        ok = 1;
        break;
      end
    end
    check(ok, "done_timeout", ok, 1);
  endtask

  initial begin
    rst = 1'b1;
    en  = 1'b0;
    di  = '0;
    wr_count = 0;
    prev_owe = 1'b0;
    last_addr = '0;
    last_dout = '0;
    for (int i = 0; i < 32; i++) begin
      bram[i] = '0;
      bram_wr[i] = 1'b0;
    end
    for (int i = 0; i < M; i++) ref_mem[i] = '0;
    #1 rst = 1'b0;

    // 1: reset held three cycles
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;

    // 2: single write with latency checks
    @(posedge clk); #1;
    en = 1'b1;
    di = 12'h123;
    push(12'h123);
    @(posedge clk); #1;
    check(owe == 1'b1, "lat_owe", owe, 1);
    check(addr == 0, "lat_addr", addr, 0);
    @(posedge clk); #1;
    en = 1'b0;
    check(done == 1'b1, "lat_done", done, 1);
    check(owe == 1'b0, "lat_owe_off", owe, 0);
    @(posedge clk); #1;
    check(done == 1'b0, "lat_done_off", done, 0);
    repeat (2) @(posedge clk);
    check(bram[0] == 12'h123, "bram0", bram[0], 12'h123);

    // 3: wrap-around from a fresh head
    do_reset(2);
    for (int i = 10; i < 16; i++) sample(DW'(i), 2);
    check(bram[0] == 12'd14, "wrap0", bram[0], 14);
    check(bram[1] == 12'd15, "wrap1", bram[1], 15);
    check(bram[2] == 12'd12, "wrap2", bram[2], 12);
    check(bram[3] == 12'd13, "wrap3", bram[3], 13);

    // 4: en held ten cycles gives one write
    sample(12'hABC, 10);
    repeat (3) @(posedge clk);

    // 5: re-rise while in WRITE/DONE is ignored
    @(posedge clk); #1;
    en = 1'b1;
    di = 12'h5A5;
    push(12'h5A5);
    @(posedge clk); #1;
    en = 1'b0;
    @(posedge clk); #1;
    en = 1'b1;
    di = 12'hFFF;
    @(posedge clk); #1;
    @(posedge clk); #1;
    en = 1'b0;
    repeat (3) @(posedge clk);
    sample(12'h777, 2);

    // 6: reset while owe is high
    @(posedge clk); #1;
    en = 1'b1;
    di = 12'h0EE;
    @(posedge clk); #1;
    check(owe == 1'b1, "abort_owe", owe, 1);
    rst = 1'b0;
    en  = 1'b0;
    sb.delete();
    wr_count = 0;
    #1;
    check(owe == 0 && done == 0 && addr == 0,
          "abort_outs", {addr, owe, done}, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    sample(12'h321, 2);
    check(bram[0] == 12'h321, "post_abort",
          bram[0], 12'h321);

    // randomized traffic
    for (int n = 0; n < 40; n++) begin
      sample(DW'($urandom),
             int'($urandom_range(1, 5)));
      repeat ($urandom_range(0, 3)) @(posedge clk);
    end
    repeat (3) @(posedge clk);

    check(sb.size() == 0, "sb_empty", sb.size(), 0);
    for (int i = 0; i < M; i++)
      check(bram[i] == ref_mem[i], "bram_final",
            bram[i], ref_mem[i]);
    for (int i = M; i < 32; i++)
      check(!bram_wr[i], "unused_slot", i, 0);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
